// File: rtl/sdm_cic_rx_if.sv
// ============================================================================
//  Module      : sdm_cic_rx_if
//  Description : Host-side read handshake of the CIC bitstream receiver.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sdm_cic_rx_if #(
    parameter int DMSB = 3
);
    logic                  pop;
    logic                  full;
    logic signed [DMSB:0]  rdata;
    logic                  ovf;

    modport master (output pop, input full, input rdata, input ovf);
    modport slave  (input pop, output full, output rdata, output ovf);
endinterface

`default_nettype wire

// File: rtl/sdm_cic_rx.sv
// ============================================================================
//  Module      : sdm_cic_rx
//  Description : 1-bit stream receiver, 2nd-order CIC decimator, one-entry
//                output register with level-full / toggle-pop handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdm_cic_rx #(
    parameter int DMSB     = 3,
    parameter int OSR_LOG2 = 4
) (
    input  wire logic                clk,
    input  wire logic                rstn,
    input  wire logic                setn,
    input  wire logic                fclk,
    input  wire logic                rx,
    input  wire logic                clear,
    sdm_cic_rx_if.slave              bus,
    output logic [1:0]               xst,
    output logic [OSR_LOG2-1:0]      cst
);
    localparam int W  = 2*OSR_LOG2 + 2;
    localparam int SH = 2*OSR_LOG2 - DMSB;
    localparam logic signed [W-1:0] Y_MAX = W'((1 << DMSB) - 1);
    localparam logic signed [W-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [2:0]            fsync_q, fsync_d;
    logic [1:0]            rsync_q, rsync_d;
    logic                  pop_dly_q, pop_dly_d;
    logic [OSR_LOG2-1:0]   cst_q, cst_d;
    logic [W-1:0]          i1_q, i1_d, i2_q, i2_d, i2p_q, i2p_d, c1p_q, c1p_d;
    logic signed [W-1:0]   comb_q, comb_d;
    logic                  dvld_q, dvld_d;
    logic                  disc_q, disc_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic [DMSB:0]         rdata_q, rdata_d;

    logic                  stb, pop_edge, load;
    logic [W-1:0]          x, i1_n, i2_n, c1, c2;
    logic signed [W-1:0]   y_sh;
    logic [DMSB:0]         y_sat;

    always_comb begin
        state_d   = state_q;
        fsync_d   = {fsync_q[1:0], fclk};
        rsync_d   = {rsync_q[0], rx};
        pop_dly_d = bus.pop;
        cst_d     = cst_q;
        i1_d      = i1_q;
        i2_d      = i2_q;
        i2p_d     = i2p_q;
        c1p_d     = c1p_q;
        comb_d    = comb_q;
        dvld_d    = 1'b0;
        disc_d    = disc_q;
        full_d    = full_q;
        ovf_d     = ovf_q;
        rdata_d   = rdata_q;

        stb      = fsync_q[1] & ~fsync_q[2];
        pop_edge = bus.pop != pop_dly_q;
        x        = rsync_q[1] ? W'(1) : {W{1'b1}};
        i1_n     = i1_q + x;
        i2_n     = i2_q + i1_n;
        c1       = i2_n - i2p_q;
        c2       = c1 - c1p_q;
        load     = dvld_q && (state_q == RUN);

        y_sh = comb_q >>> SH;
        if (y_sh > Y_MAX)
            y_sat = Y_MAX[DMSB:0];
        else if (y_sh < Y_MIN)
            y_sat = Y_MIN[DMSB:0];
        else
            y_sat = y_sh[DMSB:0];

        if (clear || !setn) begin
            // Flush the whole decimation path; a partial frame is abandoned.
            state_d = IDLE;
            cst_d   = '0;
            i1_d    = '0;
            i2_d    = '0;
            i2p_d   = '0;
            c1p_d   = '0;
            comb_d  = '0;
            disc_d  = 1'b0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = SETTLE;
                default: begin
                    if (stb) begin
                        i1_d  = i1_n;
                        i2_d  = i2_n;
                        cst_d = cst_q + OSR_LOG2'(1);
                        if (cst_q == '1) begin
                            i2p_d  = i2_n;
                            c1p_d  = c1;
                            comb_d = $signed(c2);
                            dvld_d = 1'b1;
                        end
                    end
                    // The first two comb outputs are built on zeroed history.
                    if (dvld_q && state_q == SETTLE) begin
                        disc_d = 1'b1;
                        if (disc_q)
                            state_d = RUN;
                    end
                    if (load) begin
                        if (!full_q || pop_edge) begin
                            rdata_d = y_sat;
                            full_d  = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (pop_edge) begin
                        full_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            fsync_q   <= '0;
            rsync_q   <= '0;
            pop_dly_q <= 1'b0;
            cst_q     <= '0;
            i1_q      <= '0;
            i2_q      <= '0;
            i2p_q     <= '0;
            c1p_q     <= '0;
            comb_q    <= '0;
            dvld_q    <= 1'b0;
            disc_q    <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            fsync_q   <= fsync_d;
            rsync_q   <= rsync_d;
            pop_dly_q <= pop_dly_d;
            cst_q     <= cst_d;
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            i2p_q     <= i2p_d;
            c1p_q     <= c1p_d;
            comb_q    <= comb_d;
            dvld_q    <= dvld_d;
            disc_q    <= disc_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.full  = full_q;
    assign bus.rdata = $signed(rdata_q);
    assign bus.ovf   = ovf_q;
    assign xst       = state_q;
    assign cst       = cst_q;

endmodule

`default_nettype wire

// File: tb/tb_sdm_cic_rx.sv
// ============================================================================
//  Module      : tb_sdm_cic_rx
//  Description : Self-checking bench for sdm_cic_rx with a bit-level CIC model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdm_cic_rx;
    localparam int DMSB     = 3;
    localparam int OSR_LOG2 = 4;
    localparam int R        = 1 << OSR_LOG2;
    localparam int W        = 2*OSR_LOG2 + 2;

    logic clk = 1'b0;
    logic rstn, setn, fclk, rx, clear;
    logic [1:0] xst;
    logic [OSR_LOG2-1:0] cst;

    sdm_cic_rx_if #(.DMSB(DMSB)) bus ();

    sdm_cic_rx #(.DMSB(DMSB), .OSR_LOG2(OSR_LOG2)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .setn  (setn),
        .fclk  (fclk),
        .rx    (rx),
        .clear (clear),
        .bus   (bus),
        .xst   (xst),
        .cst   (cst)
    );

    always #5 clk = ~clk;

    typedef struct { bit [3:0] pat; int exp; } vec_t;
    vec_t vecs [6];

    int total = 0;
    int bad   = 0;
    int sbq [$];
    bit auto_pop = 1'b0;
    int n_pops, last_pop;
    int m_i1, m_i2, m_i2p, m_c1p, m_cnt, m_disc;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: unbounded integer CIC, wrapped to W bits only at the comb output.
    task automatic model_bit(input bit b);
        int c1, c2, y;
        m_i1 += b ? 1 : -1;
        m_i2 += m_i1;
        m_cnt++;
        if (m_cnt == R) begin
            m_cnt = 0;
            c1 = m_i2 - m_i2p;
            m_i2p = m_i2;
            c2 = c1 - m_c1p;
            m_c1p = c1;
            c2 = c2 & ((1 << W) - 1);
            if (c2 >= (1 << (W-1))) c2 -= (1 << W);
            y = c2 >>> (2*OSR_LOG2 - DMSB);
            if (y > (1 << DMSB) - 1) y = (1 << DMSB) - 1;
            if (y < -(1 << DMSB))    y = -(1 << DMSB);
            if (m_disc < 2) m_disc++;
            else sbq.push_back(y);
        end
    endtask

    task automatic model_reset();
        m_i1 = 0; m_i2 = 0; m_i2p = 0; m_c1p = 0; m_cnt = 0; m_disc = 0;
        sbq.delete();
        n_pops = 0;
    endtask

    task automatic tick();
        int e;
        @(negedge clk);
        if (auto_pop && bus.full) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got sample %0d expected none queued", int'(bus.rdata));
            end else begin
                e = sbq.pop_front();
                chk("sb_rdata", int'(bus.rdata), e);
            end
            last_pop = int'(bus.rdata);
            n_pops++;
            bus.pop = ~bus.pop;
        end
    endtask

    task automatic send_bit(input bit b);
        model_bit(b);
        rx = b;
        repeat (4) tick();
        fclk = 1'b1;
        repeat (3) tick();
        fclk = 1'b0;
    endtask

    task automatic send_pat(input bit [3:0] pat, input int nbits);
        for (int k = 0; k < nbits; k++) send_bit(pat[3 - (k % 4)]);
    endtask

    task automatic restart();
        clear = 1'b1;
        repeat (2) tick();
        clear = 1'b0;
        repeat (3) tick();
        model_reset();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int exp_new;
        real acc, u, v;
        bit b;

        vecs[0] = '{4'b1111,  7};
        vecs[1] = '{4'b0000, -8};
        vecs[2] = '{4'b1010,  0};
        vecs[3] = '{4'b1110,  4};
        vecs[4] = '{4'b1000, -4};
        vecs[5] = '{4'b1100,  0};

        rstn = 1'b0; setn = 1'b0; clear = 1'b0; fclk = 1'b0; rx = 1'b0;
        bus.pop = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_full",  int'(bus.full), 0);
        chk("rst_rdata", int'(bus.rdata), 0);
        chk("rst_ovf",   int'(bus.ovf), 0);
        chk("rst_xst",   int'(xst), 0);
        chk("rst_cst",   int'(cst), 0);
        rstn = 1'b1;
        tick();
        setn = 1'b1;
        tick();
        tick();
        chk("xst_settle", int'(xst), 1);

        // Steady-state patterns: 2 discarded frames, then 3 checked outputs.
        auto_pop = 1'b1;
        foreach (vecs[i]) begin
            restart();
            send_pat(vecs[i].pat, 5*R);
            repeat (6) tick();
            chk("vec_npop", n_pops, 3);
            chk("vec_value", last_pop, vecs[i].exp);
        end

        // Overrun: second sample arrives while the first is unread.
        auto_pop = 1'b0;
        restart();
        send_pat(4'b1111, 3*R);
        repeat (4) tick();
        chk("ovf_full1", int'(bus.full), 1);
        chk("ovf_rdata1", int'(bus.rdata), 7);
        send_pat(4'b0000, R);
        repeat (4) tick();
        chk("ovf_set", int'(bus.ovf), 1);
        chk("ovf_full2", int'(bus.full), 1);
        chk("ovf_rdata_kept", int'(bus.rdata), 7);
        clear = 1'b1;
        tick();
        chk("clr_full", int'(bus.full), 0);
        chk("clr_ovf", int'(bus.ovf), 0);
        chk("clr_xst", int'(xst), 0);
        clear = 1'b0;

        // Pop toggled on the very clock that loads a new sample.
        restart();
        send_pat(4'b1111, 3*R);
        repeat (4) tick();
        chk("same_pre_full", int'(bus.full), 1);
        send_pat(4'b0000, R-1);
        model_bit(1'b0);
        exp_new = sbq[$];
        rx = 1'b0;
        repeat (4) tick();
        fclk = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 10; w++) begin
            tick();
            if (cst == 0) begin
                found = 1'b1;
                break;
            end
        end
        chk("same_wrap_seen", int'(found), 1);
        bus.pop = ~bus.pop;
        tick();
        chk("same_full", int'(bus.full), 1);
        chk("same_rdata", int'(bus.rdata), exp_new);
        chk("same_ovf", int'(bus.ovf), 0);
        fclk = 1'b0;
        tick();
        bus.pop = ~bus.pop;
        repeat (2) tick();
        chk("pop_full", int'(bus.full), 0);
        bus.pop = ~bus.pop;
        repeat (2) tick();
        chk("pop_empty_full", int'(bus.full), 0);
        chk("pop_empty_ovf", int'(bus.ovf), 0);
        chk("pop_empty_rdata", int'(bus.rdata), exp_new);

        // Asynchronous reset in the middle of a frame.
        restart();
        send_pat(4'b1111, 7);
        tick();
        chk("mid_cst", int'(cst), 7);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_full",  int'(bus.full), 0);
        chk("arst_rdata", int'(bus.rdata), 0);
        chk("arst_ovf",   int'(bus.ovf), 0);
        chk("arst_xst",   int'(xst), 0);
        chk("arst_cst",   int'(cst), 0);
        tick();
        rstn = 1'b1;
        #1;
        chk("arel_idle", int'(xst), 0);
        tick();
        chk("arel_settle", int'(xst), 1);
        model_reset();
        auto_pop = 1'b1;
        send_pat(4'b1110, 5*R);
        repeat (6) tick();
        chk("arel_npop", n_pops, 3);
        chk("arel_value", last_pop, 4);

        // setn low parks the block in IDLE.
        setn = 1'b0;
        repeat (2) tick();
        chk("setn_idle", int'(xst), 0);
        setn = 1'b1;

        // First-order modulator driven by a slow sine, looped into rx.
        restart();
        acc = 0.0;
        for (int k = 0; k < 150*R; k++) begin
            u = 0.7 * $sin(2.0 * 3.14159265358979 * k / (40.0 * R));
            v = acc + u;
            b = (v >= 0.0);
            acc = v - (b ? 1.0 : -1.0);
            send_bit(b);
        end
        repeat (6) tick();
        chk("sine_npop", n_pops, 148);
        chk("sine_ovf", int'(bus.ovf), 0);
        chk("sine_sb_left", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
